// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if
// Groups the PS/2 pin inputs and the key-event outputs of ps2_key_decoder.
//   ps2Ck, ps2D : raw, asynchronous PS/2 clock and data pins
//   keyStrb     : one-cycle pulse marking a completed key event
//   keyPrss     : 1 = make, 0 = break (held until next event)
//   keyCode     : scan code with prefixes stripped (held)
//   keyExt      : event was E0-prefixed (held)
//   frameErr    : one-cycle pulse on parity or stop-bit error
// master drives the pins (board / testbench), slave is the decoder.
interface ps2_key_decoder_if;
    logic       ps2Ck;
    logic       ps2D;
    logic       keyStrb;
    logic       keyPrss;
    logic [7:0] keyCode;
    logic       keyExt;
    logic       frameErr;

    modport master (
        output ps2Ck, ps2D,
        input  keyStrb, keyPrss, keyCode, keyExt, frameErr
    );

    modport slave (
        input  ps2Ck, ps2D,
        output keyStrb, keyPrss, keyCode, keyExt, frameErr
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Receive-only PS/2 keyboard decoder (scan code set 2). Synchronises and
// filters the PS/2 lines, receives 11-bit frames, strips E0/F0 prefixes,
// swallows the 8-byte Pause sequence and abandons stalled frames.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low
//   ps2_if : slave side of ps2_key_decoder_if (pins in, key events out)
//
// state    | meaning
// ---------+--------------------------------------------
// S_IDLE   | waiting for a start bit (data low on a sample)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | checking stop bit and odd parity, acting on the byte
module ps2_key_decoder #(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic           clock,
    input  logic           reset,
    ps2_key_decoder_if.slave ps2_if
);
    localparam int unsigned FILT_W = $clog2(FILTER + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic ck_meta_q, ck_sync_q, d_meta_q, d_sync_q;

    logic              ck_filt_q, ck_filt_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              sample;

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              timed_out;
    logic              brk_q, brk_d;
    logic              ext_q, ext_d;
    logic [2:0]        skip_q, skip_d;

    logic              strb_q, strb_d;
    logic              prss_q, prss_d;
    logic [7:0]        code_q, code_d;
    logic              kext_q, kext_d;
    logic              err_q, err_d;

    // Synchronisers idle high, matching an idle PS/2 line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_meta_q <= 1'b1;
            ck_sync_q <= 1'b1;
            d_meta_q  <= 1'b1;
            d_sync_q  <= 1'b1;
        end else begin
            ck_meta_q <= ps2_if.ps2Ck;
            ck_sync_q <= ck_meta_q;
            d_meta_q  <= ps2_if.ps2D;
            d_sync_q  <= d_meta_q;
        end
    end

    // The filtered clock follows only after FILTER consecutive differing
    // cycles. A flip away from 1 is a falling edge, i.e. a sample.
    always_comb begin
        ck_filt_d  = ck_filt_q;
        filt_cnt_d = '0;
        sample     = 1'b0;
        if (ck_sync_q != ck_filt_q) begin
            if (filt_cnt_q == FILT_W'(FILTER - 1)) begin
                ck_filt_d = ck_sync_q;
                sample    = ck_filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // A sample in the same cycle as the timeout wins.
    assign timed_out = (state_q != S_IDLE) && (to_cnt_q == TO_W'(TIMEOUT)) && !sample;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        brk_d     = brk_q;
        ext_d     = ext_q;
        skip_d    = skip_q;
        strb_d    = 1'b0;
        err_d     = 1'b0;
        prss_d    = prss_q;
        code_d    = code_q;
        kext_d    = kext_q;

        if (state_q == S_IDLE || sample) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_W'(TIMEOUT)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end else begin
            to_cnt_d = to_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (sample && !d_sync_q) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d   = {d_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    parity_d = d_sync_q;
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    state_d = S_IDLE;
                    if ((^{shift_q, parity_q}) && d_sync_q) begin
                        if (skip_q != 3'd0) begin
                            skip_d = skip_q - 3'd1;
                        end else if (shift_q == 8'hE1) begin
                            skip_d = 3'd7;
                        end else if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            strb_d = 1'b1;
                            code_d = shift_q;
                            prss_d = !brk_q;
                            kext_d = ext_q;
                            brk_d  = 1'b0;
                            ext_d  = 1'b0;
                        end
                    end else begin
                        err_d  = 1'b1;
                        brk_d  = 1'b0;
                        ext_d  = 1'b0;
                        skip_d = 3'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timed_out) begin
            state_d = S_IDLE;
            brk_d   = 1'b0;
            ext_d   = 1'b0;
            skip_d  = 3'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_filt_q  <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            to_cnt_q   <= '0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            skip_q     <= 3'd0;
            strb_q     <= 1'b0;
            prss_q     <= 1'b0;
            code_q     <= 8'h00;
            kext_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ck_filt_q  <= ck_filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            to_cnt_q   <= to_cnt_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            skip_q     <= skip_d;
            strb_q     <= strb_d;
            prss_q     <= prss_d;
            code_q     <= code_d;
            kext_q     <= kext_d;
            err_q      <= err_d;
        end
    end

    assign ps2_if.keyStrb  = strb_q;
    assign ps2_if.keyPrss  = prss_q;
    assign ps2_if.keyCode  = code_q;
    assign ps2_if.keyExt   = kext_q;
    assign ps2_if.frameErr = err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;
    localparam int FILTER  = 8;
    localparam int TIMEOUT = 600;
    localparam int HALF    = 12;

    logic clock;
    logic reset;
    ps2_key_decoder_if bus ();

    ps2_key_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clock  (clock),
        .reset  (reset),
        .ps2_if (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    typedef struct packed {
        logic [7:0] code;
        logic       prss;
        logic       ext;
    } ev_t;

    ev_t  got_q[$];
    int   strb_cnt = 0;
    int   err_cnt  = 0;
    logic prev_strb = 1'b0;
    logic prev_err  = 1'b0;

    always @(negedge clock) begin
        if (bus.keyStrb || bus.frameErr) begin
            check("pulse_exclusive", 32'(bus.keyStrb & bus.frameErr), 32'd0);
            check("pulse_one_cycle", 32'((bus.keyStrb & prev_strb) | (bus.frameErr & prev_err)), 32'd0);
        end
        if (bus.keyStrb) begin
            strb_cnt++;
            got_q.push_back('{code: bus.keyCode, prss: bus.keyPrss, ext: bus.keyExt});
        end
        if (bus.frameErr) err_cnt++;
        prev_strb = bus.keyStrb;
        prev_err  = bus.frameErr;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_bit(input logic b);
        @(negedge clock);
        bus.ps2D = b;
        repeat (HALF) @(negedge clock);
        bus.ps2Ck = 1'b0;
        repeat (HALF) @(negedge clock);
        bus.ps2Ck = 1'b1;
    endtask

    // cor: 0 = good, 1 = parity flipped, 2 = stop bit 0
    task automatic send_tail(input logic [7:0] b, input int cor);
        logic par;
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        par = ~(^b);
        if (cor == 1) par = ~par;
        send_bit(par);
        send_bit(cor == 2 ? 1'b0 : 1'b1);
        @(negedge clock);
        bus.ps2D = 1'b1;
        repeat (2 * HALF) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input int cor);
        send_bit(1'b0);
        send_tail(b, cor);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] code, input logic prss, input logic ext);
        check({tag, "_code"}, 32'(bus.keyCode), 32'(code));
        check({tag, "_prss"}, 32'(bus.keyPrss), 32'(prss));
        check({tag, "_ext"},  32'(bus.keyExt),  32'(ext));
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [31:0] bytes;
        logic [7:0]  cor;
        int          exp_strb;
        int          exp_err;
        logic [7:0]  code;
        logic        prss;
        logic        ext;
    } vec_t;

    function automatic vec_t mk(input string nm, input int n, input logic [31:0] bytes,
                                input logic [7:0] cor, input int es, input int ee,
                                input logic [7:0] code, input logic prss, input logic ext);
        vec_t v;
        v.name = nm; v.n = n; v.bytes = bytes; v.cor = cor;
        v.exp_strb = es; v.exp_err = ee; v.code = code; v.prss = prss; v.ext = ext;
        return v;
    endfunction

    // Reference model: byte-stream rules applied to whole frames.
    logic m_brk, m_ext;
    int   m_skip;
    ev_t  exp_q[$];
    int   m_err;

    task automatic model_byte(input logic [7:0] b, input int cor);
        if (cor != 0) begin
            m_err++;
            m_brk = 1'b0; m_ext = 1'b0; m_skip = 0;
        end else if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_q.push_back('{code: b, prss: !m_brk, ext: m_ext});
            m_brk = 1'b0; m_ext = 1'b0;
        end
    endtask

    vec_t vecs[12];
    int   s0, e0;

    initial begin
        vecs[0]  = mk("make_1C",        1, 32'h0000001C, 8'h00, 1, 0, 8'h1C, 1, 0);
        vecs[1]  = mk("break_1C",       2, 32'h00001CF0, 8'h00, 1, 0, 8'h1C, 0, 0);
        vecs[2]  = mk("ext_break_75",   3, 32'h0075F0E0, 8'h00, 1, 0, 8'h75, 0, 1);
        vecs[3]  = mk("plain_1C",       1, 32'h0000001C, 8'h00, 1, 0, 8'h1C, 1, 0);
        vecs[4]  = mk("ext_make_75",    2, 32'h000075E0, 8'h00, 1, 0, 8'h75, 1, 1);
        vecs[5]  = mk("bad_parity_1C",  1, 32'h0000001C, 8'h01, 0, 1, 8'h75, 1, 1);
        vecs[6]  = mk("good_2A",        1, 32'h0000002A, 8'h00, 1, 0, 8'h2A, 1, 0);
        vecs[7]  = mk("bad_stop_1C",    1, 32'h0000001C, 8'h02, 0, 1, 8'h2A, 1, 0);
        vecs[8]  = mk("good_2A_again",  1, 32'h0000002A, 8'h00, 1, 0, 8'h2A, 1, 0);
        vecs[9]  = mk("ext_then_bad",   3, 32'h001CF0E0, 8'h04, 1, 1, 8'h1C, 1, 0);
        vecs[10] = mk("brk_then_badstop", 3, 32'h005A5AF0, 8'h08, 1, 1, 8'h5A, 1, 0);
        vecs[11] = mk("ext_break_74",   3, 32'h0074F0E0, 8'h00, 1, 0, 8'h74, 0, 1);

        bus.ps2Ck = 1'b1;
        bus.ps2D  = 1'b1;
        reset     = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_strb", 32'(bus.keyStrb), 32'd0);
        check("rst_err",  32'(bus.frameErr), 32'd0);
        check_outs("rst", 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        foreach (vecs[k]) begin
            s0 = strb_cnt; e0 = err_cnt;
            for (int j = 0; j < vecs[k].n; j++)
                send_byte(vecs[k].bytes[8*j +: 8], int'(vecs[k].cor[2*j +: 2]));
            check({vecs[k].name, "_strobes"}, 32'(strb_cnt - s0), 32'(vecs[k].exp_strb));
            check({vecs[k].name, "_errs"},    32'(err_cnt - e0),  32'(vecs[k].exp_err));
            check_outs(vecs[k].name, vecs[k].code, vecs[k].prss, vecs[k].ext);
        end

        // Pause sequence swallowed entirely
        begin
            logic [7:0] pause_seq [8];
            pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
            s0 = strb_cnt; e0 = err_cnt;
            for (int j = 0; j < 8; j++) send_byte(pause_seq[j], 0);
            check("pause_strobes", 32'(strb_cnt - s0), 32'd0);
            send_byte(8'h1C, 0);
            check("after_pause_strobes", 32'(strb_cnt - s0), 32'd1);
            check("after_pause_errs", 32'(err_cnt - e0), 32'd0);
            check_outs("after_pause", 8'h1C, 1'b1, 1'b0);
        end

        // Timeout of a partial frame
        s0 = strb_cnt; e0 = err_cnt;
        for (int j = 0; j < 5; j++) send_bit(j == 0 ? 1'b0 : 1'b1);
        @(negedge clock);
        bus.ps2D = 1'b1;
        repeat (TIMEOUT + 20) @(negedge clock);
        check("timeout_no_err", 32'(err_cnt - e0), 32'd0);
        send_byte(8'h1C, 0);
        check("timeout_strobes", 32'(strb_cnt - s0), 32'd1);
        check("timeout_errs", 32'(err_cnt - e0), 32'd0);
        check_outs("timeout", 8'h1C, 1'b1, 1'b0);

        // Glitch of FILTER-1 cycles is ignored
        s0 = strb_cnt; e0 = err_cnt;
        @(negedge clock);
        bus.ps2D = 1'b0; bus.ps2Ck = 1'b0;
        repeat (FILTER - 1) @(negedge clock);
        bus.ps2Ck = 1'b1;
        repeat (2 * HALF) @(negedge clock);
        bus.ps2D = 1'b1;
        repeat (HALF) @(negedge clock);
        send_byte(8'h3B, 0);
        check("glitch_short_strobes", 32'(strb_cnt - s0), 32'd1);
        check("glitch_short_errs", 32'(err_cnt - e0), 32'd0);
        check("glitch_short_code", 32'(bus.keyCode), 32'h3B);

        // A FILTER-cycle low pulse registers as the start bit
        s0 = strb_cnt;
        @(negedge clock);
        bus.ps2D = 1'b0; bus.ps2Ck = 1'b0;
        repeat (FILTER) @(negedge clock);
        bus.ps2Ck = 1'b1;
        repeat (HALF) @(negedge clock);
        send_tail(8'h2A, 0);
        check("glitch_full_strobes", 32'(strb_cnt - s0), 32'd1);
        check("glitch_full_code", 32'(bus.keyCode), 32'h2A);

        // Reset mid-frame
        s0 = strb_cnt; e0 = err_cnt;
        for (int j = 0; j < 5; j++) send_bit(j == 0 ? 1'b0 : 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_strb", 32'(bus.keyStrb), 32'd0);
        check("midrst_err",  32'(bus.frameErr), 32'd0);
        check_outs("midrst", 8'h00, 1'b0, 1'b0);
        bus.ps2D = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("midrst_no_pulse", 32'((strb_cnt - s0) + (err_cnt - e0)), 32'd0);
        send_byte(8'h1C, 0);
        check("midrst_strobes", 32'(strb_cnt - s0), 32'd1);
        check("midrst_errs", 32'(err_cnt - e0), 32'd0);
        check_outs("midrst_after", 8'h1C, 1'b1, 1'b0);

        // Randomised frames against the reference model
        m_brk = 1'b0; m_ext = 1'b0; m_skip = 0; m_err = 0;
        exp_q.delete();
        got_q.delete();
        e0 = err_cnt;
        for (int f = 0; f < 80; f++) begin
            logic [7:0] b;
            int r, cor;
            r = $urandom_range(0, 15);
            case (r)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'hE1;
                default: b = 8'($urandom_range(0, 255));
            endcase
            cor = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
            model_byte(b, cor);
            send_byte(b, cor);
            check("rand_event_count", 32'(got_q.size()), 32'(exp_q.size()));
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                ev_t g, x;
                g = got_q.pop_front();
                x = exp_q.pop_front();
                check("rand_event", 32'(g), 32'(x));
            end
            got_q.delete();
            exp_q.delete();
            check("rand_errs", 32'(err_cnt - e0), 32'(m_err));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
